// File: rtl/alu_lane_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_lane_sequencer_pkg
//
// Shared GPU package for the ALU lane sequencer slice.
//   - seq_state_e : two-state sequencer FSM encoding (idle / warp held)
//   - pid_width() : width of a packet-id field for a given packet count,
//                   never narrower than one bit
// -----------------------------------------------------------------------------
package alu_lane_sequencer_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } seq_state_e;

    // A single-packet warp still needs a 1-bit pid port.
    function automatic int unsigned pid_width(int unsigned num_pkts);
        return (num_pkts > 1) ? $clog2(num_pkts) : 1;
    endfunction

endpackage

// File: rtl/VX_priority_encoder.sv
// -----------------------------------------------------------------------------
// VX_priority_encoder
//
// Finds the lowest set bit of a request vector.
//
// Parameters
//   N  : request vector width
//   LN : index width
//
// Ports
//   data_in : request vector
//   index   : position of the lowest set bit (0 when data_in is all zero)
//   onehot  : one-hot mask of that bit (all zero when data_in is all zero)
// -----------------------------------------------------------------------------
module VX_priority_encoder #(
    parameter int unsigned N  = 4,
    parameter int unsigned LN = 2
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] index,
    output logic [N-1:0]  onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index  = '0;
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) begin
                index     = LN'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_lane_sequencer.sv
// -----------------------------------------------------------------------------
// alu_lane_sequencer
//
// Splits a warp request (NUM_THREADS threads) into ALU packets of NUM_LANES
// lanes each. Packets whose thread mask slice is all zero are skipped; a warp
// with an all-zero mask still produces a single empty packet (pid 0) so the
// downstream ALU sees the warp's metadata exactly once.
//
// Parameters
//   NUM_THREADS : threads per warp request
//   NUM_LANES   : lanes per packet (must divide NUM_THREADS)
//   DATAW       : per-thread payload bits
//   METAW       : shared per-warp metadata bits
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : warp request handshake
//   in_tmask/data/meta    : warp thread mask, per-thread payload, metadata
//   out_valid / out_ready : packet handshake toward the ALU
//   out_tmask/data/meta   : packet lane mask, per-lane payload, metadata
//   out_pid               : packet index within the warp
//   out_sop / out_eop     : first / last emitted packet of the warp
// -----------------------------------------------------------------------------
module alu_lane_sequencer
    import alu_lane_sequencer_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned DATAW       = 64,
    parameter int unsigned METAW       = 32,
    localparam int unsigned NUM_PKTS   = NUM_THREADS / NUM_LANES,
    localparam int unsigned PID_WIDTH  = pid_width(NUM_PKTS)
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_THREADS-1:0]       in_tmask,
    input  logic [NUM_THREADS*DATAW-1:0] in_data,
    input  logic [METAW-1:0]             in_meta,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LANES-1:0]         out_tmask,
    output logic [NUM_LANES*DATAW-1:0]   out_data,
    output logic [METAW-1:0]             out_meta,
    output logic [PID_WIDTH-1:0]         out_pid,
    output logic                         out_sop,
    output logic                         out_eop
);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    seq_state_e                   state_q;
    logic                         valid_q;
    logic                         sop_q;
    logic                         eop_q;
    logic [PID_WIDTH-1:0]         pid_q;
    // Nonempty packets strictly above the one currently presented.
    logic [NUM_PKTS-1:0]          rem_q;
    logic [NUM_THREADS-1:0]       tmask_q;
    logic [NUM_THREADS*DATAW-1:0] data_q;
    logic [METAW-1:0]             meta_q;
    logic [NUM_LANES-1:0]         out_tmask_q;
    logic [NUM_LANES*DATAW-1:0]   out_data_q;

    // ---------------------------------------------------------------------
    // Handshakes
    // ---------------------------------------------------------------------
    logic fire_out;
    logic capture;

    assign fire_out = valid_q & out_ready;
    // A new warp may be taken while the last packet of the current one leaves.
    assign in_ready = (state_q == StIdle) | (fire_out & eop_q);
    assign capture  = in_valid & in_ready;

    // ---------------------------------------------------------------------
    // Packet selection
    // ---------------------------------------------------------------------
    logic [NUM_PKTS-1:0] nonempty_new;

    always_comb begin
        nonempty_new = '0;
        for (int unsigned p = 0; p < NUM_PKTS; p++) begin
            nonempty_new[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
        end
    end

    // On capture the search runs over the fresh warp's whole vector; while
    // advancing it runs over what is left above the current pid, so the
    // lowest hit is always the next packet to emit.
    logic [NUM_PKTS-1:0]  enc_in;
    logic [PID_WIDTH-1:0] enc_index;
    logic [NUM_PKTS-1:0]  enc_onehot;

    assign enc_in = capture ? nonempty_new : rem_q;

    VX_priority_encoder #(
        .N  (NUM_PKTS),
        .LN (PID_WIDTH)
    ) u_next_pkt (
        .data_in (enc_in),
        .index   (enc_index),
        .onehot  (enc_onehot)
    );

    logic [NUM_PKTS-1:0]          rem_next;
    logic [NUM_THREADS-1:0]       src_tmask;
    logic [NUM_THREADS*DATAW-1:0] src_data;
    logic [NUM_LANES-1:0]         pkt_tmask;
    logic [NUM_LANES*DATAW-1:0]   pkt_data;
    int unsigned                  pkt_lane_base;

    always_comb begin
        rem_next      = enc_in & ~enc_onehot;
        src_tmask     = capture ? in_tmask : tmask_q;
        src_data      = capture ? in_data : data_q;
        // All-zero warps give index 0 here, which yields the empty pid 0 packet.
        pkt_lane_base = 32'(enc_index) * NUM_LANES;
        pkt_tmask     = src_tmask[pkt_lane_base +: NUM_LANES];
        pkt_data      = src_data[pkt_lane_base*DATAW +: NUM_LANES*DATAW];
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            pid_q       <= '0;
            rem_q       <= '0;
            out_tmask_q <= '0;
        end else if (capture || (fire_out && !eop_q)) begin
            // Load the next packet: first of a new warp, or next of this one.
            state_q     <= StBusy;
            valid_q     <= 1'b1;
            sop_q       <= capture;
            eop_q       <= (rem_next == '0);
            pid_q       <= enc_index;
            rem_q       <= rem_next;
            out_tmask_q <= pkt_tmask;
            out_data_q  <= pkt_data;
            if (capture) begin
                tmask_q <= in_tmask;
                data_q  <= in_data;
                meta_q  <= in_meta;
            end
        end else if (fire_out) begin
            // Last packet left and no new warp arrived.
            state_q <= StIdle;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_pid   = pid_q;
    assign out_tmask = out_tmask_q;
    assign out_data  = out_data_q;
    assign out_meta  = meta_q;

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_lane_sequencer
//
// Self-checking bench: a queue of expected packets is built from each accepted
// warp and compared with the DUT outputs every cycle; directed scenarios pin
// the emitted packet sequence against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_alu_lane_sequencer;

    localparam int NT = 8;
    localparam int NL = 2;
    localparam int DW = 64;
    localparam int MW = 32;
    localparam int PW = 2;
    localparam int NP = NT / NL;

    typedef logic [255:0] w_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NT-1:0]    in_tmask = '0;
    logic [NT*DW-1:0] in_data = '0;
    logic [MW-1:0]    in_meta = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [NL-1:0]    out_tmask;
    logic [NL*DW-1:0] out_data;
    logic [MW-1:0]    out_meta;
    logic [PW-1:0]    out_pid;
    logic             out_sop;
    logic             out_eop;

    always #5 clk = ~clk;

    alu_lane_sequencer #(
        .NUM_THREADS (NT),
        .NUM_LANES   (NL),
        .DATAW       (DW),
        .METAW       (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tmask  (in_tmask),
        .in_data   (in_data),
        .in_meta   (in_meta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tmask (out_tmask),
        .out_data  (out_data),
        .out_meta  (out_meta),
        .out_pid   (out_pid),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    typedef struct {
        int            pid;
        logic [NL-1:0] tmask;
        logic [NL*DW-1:0] data;
        logic [MW-1:0] meta;
        bit            sop;
        bit            eop;
    } pkt_t;

    typedef struct {
        int            pid;
        logic [NL-1:0] tmask;
        bit            sop;
        bit            eop;
        int            cyc;
    } log_t;

    pkt_t q[$];
    log_t lg[$];
    int   cyc = 0;
    bit   started = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   m_rdy;
    bit   c_valid;
    bit   c_rdy;

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected packets of a warp: every nonempty lane group in ascending order,
    // or a single empty pid-0 packet when the mask is all zero.
    function automatic void add_warp(input logic [NT-1:0] tm, input logic [NT*DW-1:0] d,
                                     input logic [MW-1:0] m);
        int   ps[$];
        pkt_t pk;
        for (int p = 0; p < NP; p++) if (tm[p*NL +: NL] != '0) ps.push_back(p);
        if (ps.size() == 0) ps.push_back(0);
        foreach (ps[i]) begin
            pk.pid   = ps[i];
            pk.tmask = tm[ps[i]*NL +: NL];
            pk.data  = d[ps[i]*NL*DW +: NL*DW];
            pk.meta  = m;
            pk.sop   = (i == 0);
            pk.eop   = (i == ps.size() - 1);
            q.push_back(pk);
        end
    endfunction

    // Reference model update.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            started = 1;
        end else begin
            m_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && m_rdy) add_warp(in_tmask, in_data, in_meta);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            c_valid = (q.size() > 0);
            c_rdy   = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("out_valid", w_t'(out_valid), w_t'(c_valid));
            chk("in_ready", w_t'(in_ready), w_t'(c_rdy));
            if (c_valid && out_valid) begin
                chk("out_pid", w_t'(out_pid), w_t'(q[0].pid));
                chk("out_tmask", w_t'(out_tmask), w_t'(q[0].tmask));
                chk("out_data", w_t'(out_data), w_t'(q[0].data));
                chk("out_meta", w_t'(out_meta), w_t'(q[0].meta));
                chk("out_sop", w_t'(out_sop), w_t'(q[0].sop));
                chk("out_eop", w_t'(out_eop), w_t'(q[0].eop));
            end
            if (!reset && out_valid && out_ready)
                lg.push_back('{int'(out_pid), out_tmask, out_sop, out_eop, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_warp(input logic [NT-1:0] tm);
        in_tmask = tm;
        for (int i = 0; i < NT*DW/32; i++) in_data[i*32 +: 32] = $urandom;
        in_meta  = $urandom;
        in_valid = 1'b1;
    endtask

    // Presents a warp and returns just after the edge that accepted it.
    task automatic push_warp(input logic [NT-1:0] tm);
        bit acc = 0;
        set_warp(tm);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (!acc) chk("accept_timeout", w_t'(acc), w_t'(1));
    endtask

    task automatic chk_log(input int idx, input int pid, input bit sop, input bit eop,
                           input logic [NL-1:0] tm);
        if (idx < lg.size()) begin
            chk("log_pid", w_t'(lg[idx].pid), w_t'(pid));
            chk("log_sop", w_t'(lg[idx].sop), w_t'(sop));
            chk("log_eop", w_t'(lg[idx].eop), w_t'(eop));
            chk("log_tmask", w_t'(lg[idx].tmask), w_t'(tm));
        end else begin
            chk("log_missing", w_t'(lg.size()), w_t'(idx + 1));
        end
    endtask

    initial begin
        logic [NT-1:0] tm;
        bit acc;

        // Reset state.
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", w_t'(out_valid), w_t'(0));
        chk("rst_out_sop", w_t'(out_sop), w_t'(0));
        chk("rst_out_eop", w_t'(out_eop), w_t'(0));
        chk("rst_out_pid", w_t'(out_pid), w_t'(0));
        chk("rst_out_tmask", w_t'(out_tmask), w_t'(0));
        chk("rst_in_ready", w_t'(in_ready), w_t'(1));
        step();

        // Full mask: four packets on consecutive cycles.
        lg.delete();
        push_warp(8'hFF);
        in_valid = 1'b0;
        repeat (6) step();
        chk("full_count", w_t'(lg.size()), w_t'(4));
        for (int i = 0; i < 4; i++) begin
            chk_log(i, i, i == 0, i == 3, 2'b11);
            if (i < lg.size()) chk("full_consec", w_t'(lg[i].cyc - lg[0].cyc), w_t'(i));
        end

        // Single middle packet.
        lg.delete();
        push_warp(8'b0011_0000);
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_count", w_t'(lg.size()), w_t'(1));
        chk_log(0, 2, 1, 1, 2'b11);

        // Skip of the inner empty packets.
        lg.delete();
        push_warp(8'b1100_0011);
        in_valid = 1'b0;
        repeat (5) step();
        chk("skip_count", w_t'(lg.size()), w_t'(2));
        chk_log(0, 0, 1, 0, 2'b11);
        chk_log(1, 3, 0, 1, 2'b11);

        // Backpressure on pid 1 for three cycles.
        lg.delete();
        push_warp(8'hFF);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_pid", w_t'(out_pid), w_t'(1));
            chk("hold_in_ready", w_t'(in_ready), w_t'(0));
            step();
        end
        out_ready = 1'b1;
        repeat (5) step();
        chk("hold_count", w_t'(lg.size()), w_t'(4));
        for (int i = 0; i < 4; i++) chk_log(i, i, i == 0, i == 3, 2'b11);
        if (lg.size() >= 2) chk("hold_gap", w_t'(lg[1].cyc - lg[0].cyc), w_t'(4));

        // Back-to-back warps with continuous in_valid.
        lg.delete();
        push_warp(8'hFF);
        push_warp(8'h01);
        in_valid = 1'b0;
        repeat (5) step();
        chk("b2b_count", w_t'(lg.size()), w_t'(5));
        chk_log(3, 3, 0, 1, 2'b11);
        chk_log(4, 0, 1, 1, 2'b01);
        if (lg.size() >= 5) chk("b2b_gap", w_t'(lg[4].cyc - lg[3].cyc), w_t'(1));

        // Reset mid-warp after pid 1 has been taken.
        lg.delete();
        push_warp(8'hFF);
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", w_t'(out_valid), w_t'(0));
        chk("midrst_in_ready", w_t'(in_ready), w_t'(1));
        chk("midrst_count", w_t'(lg.size()), w_t'(2));
        chk_log(0, 0, 1, 0, 2'b11);
        chk_log(1, 1, 0, 0, 2'b11);
        step();
        lg.delete();
        push_warp(8'h0C);
        in_valid = 1'b0;
        repeat (4) step();
        chk("postrst_count", w_t'(lg.size()), w_t'(1));
        chk_log(0, 1, 1, 1, 2'b11);

        // All-zero mask.
        lg.delete();
        push_warp(8'h00);
        in_valid = 1'b0;
        repeat (3) step();
        chk("zero_count", w_t'(lg.size()), w_t'(1));
        chk_log(0, 0, 1, 1, 2'b00);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                tm = '0;
                if ($urandom_range(0, 9) != 0) begin
                    for (int p = 0; p < NP; p++)
                        if ($urandom_range(0, 1) == 1) tm[p*NL +: NL] = NL'($urandom_range(1, 3));
                end
                set_warp(tm);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("drained", w_t'(out_valid), w_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
